// File: rtl/program_loader_if.sv
// Stream and program-memory write port bundle for program_loader.
// master = loader side, slave = byte source / instruction memory side.
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [31:0]       mem_write_data;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_address, mem_write_enable, mem_write_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian words into program memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  program_loader_if.master    bus,
  input  logic                load_req,
  output logic                cpu_reset_n,
  output logic                done,
  output logic                error
);

  localparam int          IDX_W    = ADDR_W - 2;
  localparam logic [15:0] CAPACITY = 16'(MEM_BYTES / 4);

  localparam logic [2:0] LEN0  = 3'd0;
  localparam logic [2:0] LEN1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
`endif
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERROR = 3'd6;

  logic [2:0]       state;
  logic [15:0]      count;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      word_q;
  logic [15:0]      len_full;
  logic             last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign len_full  = {bus.rx_data, count[7:0]};
  assign last_word = ({{(16-IDX_W){1'b0}}, word_idx} == (count - 16'd1));

  // Where a finished image goes: straight to DONE, or via the checksum byte.
  logic [2:0] image_end;
`ifdef LOADER_CHECKSUM_EN
  assign image_end = CHECK;
`else
  assign image_end = DONE;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= LEN0;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        LEN0: if (bus.rx_valid) begin
          count[7:0] <= bus.rx_data;
          state      <= LEN1;
        end
        LEN1: if (bus.rx_valid) begin
          count    <= len_full;
          word_idx <= '0;
          byte_idx <= '0;
          if (len_full > CAPACITY)   state <= ERROR;
          else if (len_full == '0)   state <= image_end;
          else                       state <= DATA;
        end
        DATA: if (bus.rx_valid) begin
          word_q[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
          byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum + bus.rx_data;
`endif
          if (byte_idx == 2'd3) state <= WRITE;
        end
        WRITE: begin
          if (last_word) state <= image_end;
          else begin
            word_idx <= word_idx + 1'b1;
            state    <= DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (bus.rx_valid) begin
          state <= (bus.rx_data == csum) ? DONE : ERROR;
        end
`endif
        DONE, ERROR: if (load_req) begin
          state    <= LEN0;
          count    <= '0;
          word_idx <= '0;
          byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
        default: state <= LEN0;
      endcase
    end
  end

  // Every output is a pure decode of registered state, never of an input.
  always_comb begin
    bus.rx_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state == CHECK) bus.rx_ready = 1'b1;
`endif
  end

  assign bus.mem_write_enable = (state == WRITE);
  assign bus.mem_address      = {word_idx, 2'b00};
  assign bus.mem_write_data   = word_q;
  assign cpu_reset_n          = (state == DONE);
  assign done                 = (state == DONE);
  assign error                = (state == ERROR);

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the CPU's instruction memory. Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit words. Writes each word into program memory through its write port, which the core otherwise ties off. Holds the core in reset until the image is fully written, then releases it.

## Interface
- MEM_BYTES, 32, program memory size in bytes; multiple of 4; capacity = MEM_BYTES/4 words
- ADDR_W, 5, byte-address width; must equal $clog2(MEM_BYTES)
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready
- load_req  in  1  restart load; honoured only in DONE or ERROR
- mem_address  out  ADDR_W  byte address of the write; always word aligned, bits[1:0]=0
- mem_write_enable  out  1  one-cycle write strobe
- mem_write_data  out  32  assembled word
- cpu_reset_n  out  1  core reset; low except in DONE
- done  out  1  image loaded, core running
- error  out  1  load aborted

## Operation
- Stream format: count[7:0], count[15:8] (count = number of words), then count×4 payload bytes, least-significant byte first per word. With LOADER_CHECKSUM_EN, one checksum byte follows.
- States and transitions:
  - LEN0: rx_ready=1. A transfer stores count[7:0], then goes to LEN1.
  - LEN1: rx_ready=1. A transfer stores count[15:8], then:
    - count > MEM_BYTES/4 goes to ERROR.
    - count == 0 goes to DONE, or to CHECK if the checksum is enabled.
    - Otherwise goes to DATA with word_idx=0 and byte_idx=0.
  - DATA: rx_ready=1. Each transfer writes rx_data into word byte lane byte_idx and increments byte_idx (2-bit, wraps). The transfer with byte_idx==3 goes to WRITE.
  - WRITE: rx_ready=0. mem_write_enable=1, mem_address=word_idx×4, mem_write_data=assembled word. Next state:
    - word_idx == count−1 goes to DONE, or to CHECK if the checksum is enabled.
    - Otherwise word_idx increments and the state returns to DATA.
  - CHECK: rx_ready=1. A transfer compares rx_data with the running sum. Equal goes to DONE; unequal goes to ERROR.
  - DONE: cpu_reset_n=1, done=1, rx_ready=0. A load_req of 1 goes to LEN0.
  - ERROR: error=1, cpu_reset_n=0, rx_ready=0. A load_req of 1 goes to LEN0. Otherwise ERROR holds indefinitely.
- Going to LEN0 clears count, word_idx, byte_idx and the checksum accumulator.
- load_req is ignored in LEN0, LEN1, DATA, WRITE and CHECK.
- rx_data is ignored when rx_valid=0. Gaps in rx_valid of any length stall the loader without losing state.
- Memory contents are never cleared. Words beyond count keep their previous values.
- Arithmetic:
  - count is 16-bit and is compared unsigned.
  - word_idx is ADDR_W−2 bits wide. It cannot overflow because count ≤ capacity.

## Timing
- All outputs decode from registered state and registered datapath. There is no combinational path from any input to any output.
- Reset values: state=LEN0, rx_ready=1, mem_write_enable=0, mem_address=0, mem_write_data=0, cpu_reset_n=0, done=0, error=0.
- Reset mid-load returns to LEN0. Memory already written stays written. reset_n overrides load_req.
- Write latency: mem_write_enable is high in the cycle after the 4th byte of a word transfers. It is high for exactly 1 cycle.
- Minimum cost is 5 cycles per word (4 byte transfers plus 1 WRITE cycle).
- cpu_reset_n rises in the first DONE cycle. It falls in the cycle after the DONE-state load_req.
- The final memory write completes before cpu_reset_n rises: the WRITE cycle precedes DONE.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit accumulator sums every payload byte, modulo 256. The length bytes are excluded.
  - The CHECK state is present. A mismatch goes to ERROR, and the core stays in reset.
- LOADER_CHECKSUM_EN undefined:
  - There is no accumulator and no CHECK state.
  - LEN1 (when count == 0) and the last WRITE go directly to DONE.

## Test plan
- Two-word load: stream 02 00 93 00 50 00 13 01 10 00, with back-to-back rx_valid.
  - Required: write addr 0x00 data 0x00500093, then write addr 0x04 data 0x00100113.
  - Required: done=1 and cpu_reset_n=1 in the cycle after the 2nd write. With LOADER_CHECKSUM_EN, the stream also carries checksum byte 07.
- Checksum mismatch (LOADER_CHECKSUM_EN): the same stream with checksum 08.
  - Required: both writes occur, then error=1, cpu_reset_n stays 0, rx_ready=0.
- Overflow with MEM_BYTES=32: stream 09 00.
  - Required: ERROR after the 2nd byte, no mem_write_enable pulse.
  - Then load_req=1 gives LEN0 with rx_ready=1, and a fresh two-word load succeeds.
- Backpressure: the two-word stream with rx_valid low for 3 cycles between every byte, and junk on rx_data while rx_valid=0.
  - Required: identical writes and data to the two-word load; no extra writes.
- Reset mid-load: reset_n pulsed low after 5 payload bytes.
  - Required: the addr 0x00 write has already occurred; the loader is back in LEN0 with cpu_reset_n=0.
  - Then a 1-word stream 01 00 EF BE AD DE writes 0xDEADBEEF at addr 0x00.
- Reload from DONE: load_req pulse while in DONE.
  - Required: cpu_reset_n=0 in the following cycle, rx_ready=1, done=0.
  - Count 0 (stream 00 00, plus checksum 00 if LOADER_CHECKSUM_EN): DONE with no writes.
